// File: rtl/ldpc_pkg.sv
// Shared LDPC base-matrix constants and scheduler state encoding.
// Modules take these as parameter defaults so a code variant can override them.
package ldpc_pkg;

   localparam int Z               = 54;
   localparam int NUM_INFO_BLKS   = 20;
   localparam int NUM_PARITY_BLKS = 4;
   localparam int TOTAL_BLKS      = NUM_INFO_BLKS + NUM_PARITY_BLKS;
   localparam int ENTRY_W         = 8;

   localparam logic [ENTRY_W-1:0] NULL_ENTRY = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_DRAIN,
      S_DONE
   } sched_state_t;

endpackage

// File: rtl/sched_cmd_reg.sv
// Command output register: loads a new command, holds it under backpressure,
// and is cleared by a frame abort.
module sched_cmd_reg
   import ldpc_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         load,
   input  logic         next_valid,
   input  logic [W-1:0] next_data,
   output logic         valid,
   output logic [W-1:0] data
);

   // Payload is zeroed whenever no command is held, so idle fields read as 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (flush) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (load) begin
         valid <= next_valid;
         data  <= next_valid ? next_data : '0;
      end
   end

endmodule

// File: rtl/proto_matrix_scheduler.sv
// Scans the information part of a QC-LDPC base matrix row by row and issues
// one shift command per non-null circulant plus a row-close command per row.
module proto_matrix_scheduler
   import ldpc_pkg::*;
#(
   parameter int Z               = ldpc_pkg::Z,
   parameter int NUM_INFO_BLKS   = ldpc_pkg::NUM_INFO_BLKS,
   parameter int NUM_PARITY_BLKS = ldpc_pkg::NUM_PARITY_BLKS,
   parameter int TOTAL_BLKS      = NUM_INFO_BLKS + NUM_PARITY_BLKS,
   parameter int ENTRY_W         = ldpc_pkg::ENTRY_W,
   localparam int ADDR_W  = $clog2(NUM_PARITY_BLKS * TOTAL_BLKS),
   localparam int ROW_W   = $clog2(NUM_PARITY_BLKS),
   localparam int COL_W   = $clog2(NUM_INFO_BLKS),
   localparam int SHIFT_W = $clog2(Z),
   localparam int NNZ_W   = $clog2(NUM_PARITY_BLKS * NUM_INFO_BLKS + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic               start_ready,
   input  logic               abort,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [ENTRY_W-1:0] rom_data,
   output logic               cmd_valid,
   input  logic               cmd_ready,
   output logic [ROW_W-1:0]   cmd_row,
   output logic [COL_W-1:0]   cmd_col,
   output logic [SHIFT_W-1:0] cmd_shift,
   output logic               cmd_last,
   output logic               cmd_null,
   output logic               done,
   output logic [NNZ_W-1:0]   nnz_count,
   output logic               cfg_err
);

   localparam int PAY_W = ROW_W + COL_W + SHIFT_W + 2;
   localparam logic [ROW_W-1:0]   LAST_ROW  = ROW_W'(NUM_PARITY_BLKS - 1);
   localparam logic [COL_W-1:0]   LAST_COL  = COL_W'(NUM_INFO_BLKS - 1);
   localparam logic [ENTRY_W-1:0] NULL_CODE = '1;
   localparam logic [ENTRY_W-1:0] Z_CODE    = ENTRY_W'(Z);

   sched_state_t     state, state_nxt;
   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] col;
   logic             active, start_acc, load, scan_load, last_col, last_row;
   logic             entry_null, entry_bad, entry_ok, issue;
   logic [SHIFT_W-1:0] shift_nxt;
   logic [PAY_W-1:0]   pay_nxt, pay;

   assign active     = (state != S_IDLE);
   assign start_acc  = (state == S_IDLE) && start && !abort;
   assign load       = !cmd_valid || cmd_ready;
   assign scan_load  = (state == S_SCAN) && load;
   assign last_col   = (col == LAST_COL);
   assign last_row   = (row == LAST_ROW);

   // Out-of-range shifts flag cfg_err and are then handled exactly like null.
   assign entry_null = (rom_data == NULL_CODE);
   assign entry_bad  = !entry_null && (rom_data >= Z_CODE);
   assign entry_ok   = !entry_null && !entry_bad;
   assign issue      = scan_load && (entry_ok || last_col);
   assign shift_nxt  = entry_ok ? rom_data[SHIFT_W-1:0] : '0;
   assign pay_nxt    = {row, col, shift_nxt, last_col, !entry_ok};

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      // NOTE: default assignment first so no path through the case infers a latch.
      state_nxt = state;
      case (state)
         S_IDLE:  if (start_acc) state_nxt = S_SCAN;
         S_SCAN: begin
            if (abort)                                state_nxt = S_IDLE;
            else if (scan_load && last_col && last_row) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (abort)                        state_nxt = S_IDLE;
            else if (cmd_valid && cmd_ready)  state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      start_ready = (state == S_IDLE);
      done        = (state == S_DONE);
      rom_addr    = '0;
      if (state == S_SCAN)
         rom_addr = ADDR_W'(row) * ADDR_W'(TOTAL_BLKS) + ADDR_W'(col);
   end

   // Scan position only moves when the current entry has been consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row <= '0;
         col <= '0;
      end else if (start_acc) begin
         row <= '0;
         col <= '0;
      end else if (scan_load && !abort) begin
         if (last_col) begin
            col <= '0;
            row <= row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                     nnz_count <= '0;
      else if (start_acc)                             nnz_count <= '0;
      else if (cmd_valid && cmd_ready && !cmd_null)   nnz_count <= nnz_count + NNZ_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      cfg_err <= 1'b0;
      else if (scan_load && entry_bad) cfg_err <= 1'b1;
   end

   sched_cmd_reg #(
      .W (PAY_W)
   ) u_cmd_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (abort && active),
      .load       (load),
      .next_valid (issue),
      .next_data  (pay_nxt),
      .valid      (cmd_valid),
      .data       (pay)
   );

   assign {cmd_row, cmd_col, cmd_shift, cmd_last, cmd_null} = pay;

endmodule

// File: doc/proto_matrix_scheduler.md
PROTO_MATRIX_SCHEDULER -- requirements
Module: proto_matrix_scheduler

Interface
REQ-001 Parameter Z, default 54: circulant size.
REQ-002 Parameter NUM_INFO_BLKS, default 20: info block columns scanned per row.
REQ-003 Parameter NUM_PARITY_BLKS, default 4: base-matrix rows.
REQ-004 Parameter TOTAL_BLKS, default NUM_INFO_BLKS+NUM_PARITY_BLKS: row stride in ROM.
REQ-005 Parameter ENTRY_W, default 8: ROM entry width; all-ones = null circulant.
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  frame request; accepted only when start_ready=1.
REQ-009 start_ready  output  1  high in IDLE.
REQ-010 abort  input  1  synchronous frame cancel.
REQ-011 rom_addr  output  $clog2(NUM_PARITY_BLKS*TOTAL_BLKS)  ROM address = row*TOTAL_BLKS+col.
REQ-012 rom_data  input  ENTRY_W  asynchronous ROM read data, valid same cycle as rom_addr.
REQ-013 cmd_valid, cmd_ready  output/input  1 each  command handshake to shifter/accumulator datapath.
REQ-014 cmd_row  output  $clog2(NUM_PARITY_BLKS); cmd_col  output  $clog2(NUM_INFO_BLKS); cmd_shift  output  $clog2(Z).
REQ-015 cmd_last  output  1  final command of current row; cmd_null  output  1  row-close marker carrying no shift.
REQ-016 done  output  1  one-cycle pulse at frame completion.
REQ-017 nnz_count  output  $clog2(NUM_PARITY_BLKS*NUM_INFO_BLKS+1)  non-null commands issued this frame.
REQ-018 cfg_err  output  1  sticky: non-null entry with value >= Z encountered.

Function
REQ-019 FSM states IDLE, SCAN, DRAIN, DONE.
REQ-020 IDLE: start&start_ready -> SCAN; row/col counters cleared, nnz_count cleared; cfg_err not cleared.
REQ-021 SCAN: rom_addr driven from registered row/col; scan order row-major, col 0..NUM_INFO_BLKS-1 within row 0..NUM_PARITY_BLKS-1.
REQ-022 Output register loads when (!cmd_valid | cmd_ready); counters advance only on a load cycle.
REQ-023 Non-null entry (< Z): load cmd_valid=1, row, col, cmd_shift=rom_data[$clog2(Z)-1:0], cmd_null=0; nnz_count increments on the handshake.
REQ-024 Null entry on col < NUM_INFO_BLKS-1: skipped in one cycle, no command.
REQ-025 Last column: command always issued with cmd_last=1; if that entry is null, cmd_null=1 and cmd_shift=0.
REQ-026 Entry >= Z and != all-ones: set cfg_err, treat as null.
REQ-027 After last column of last row is loaded -> DRAIN; DRAIN holds until final command handshakes -> DONE.
REQ-028 DONE: done=1 for exactly one cycle -> IDLE.
REQ-029 Latency: start accepted in cycle N, first possible cmd_valid in cycle N+2.
REQ-030 Backpressure: while cmd_valid & !cmd_ready, all cmd_* outputs and counters hold stable.
REQ-031 Zero stall: with cmd_ready tied high, one ROM entry consumed per cycle; frame takes NUM_PARITY_BLKS*NUM_INFO_BLKS+3 cycles start-to-done.
REQ-032 abort in any non-IDLE state: next cycle IDLE, cmd_valid=0, no done pulse; abort in IDLE ignored; abort wins over start in same cycle.

Reset
REQ-033 rst_n low: state IDLE, start_ready=1, cmd_valid=0, all cmd_* fields 0, done=0, nnz_count=0, cfg_err=0, rom_addr=0, immediately and asynchronously, including mid-frame.
REQ-034 Reset deassertion: first start accepted no earlier than the first rising edge after release.

Structure
REQ-035 Shared package ldpc_pkg holds Z, NUM_INFO_BLKS, NUM_PARITY_BLKS, TOTAL_BLKS, ENTRY_W, NULL_ENTRY constant and the sched_state_t enum.
REQ-036 One sub-module natural: sched_cmd_reg (command output register with load/hold); ROM instantiated outside this block.

Verification
REQ-037 ROM all null except last columns, cmd_ready=1, start -> 4 commands, each cmd_null=1, cmd_last=1, rows 0..3; nnz_count=0; done at cycle 83.
REQ-038 Row 0 entries col0=5, col3=53, col19=0, rest null; other rows null -> commands (0,0,5),(0,3,53),(0,19,0,last); nnz_count=3.
REQ-039 Same ROM, cmd_ready low for 10 cycles on first command -> cmd_* stable all 10 cycles, no command lost or duplicated.
REQ-040 Entry row1 col7=60 -> cfg_err=1 after that cycle, no command for (1,7), cfg_err persists into next frame.
REQ-041 abort asserted at scan row 2 -> cmd_valid=0 next cycle, no done, start_ready=1; new start completes full frame normally.
REQ-042 rst_n pulsed low mid-DRAIN -> outputs at reset values within same cycle; subsequent frame matches REQ-038 result.
